// File: rtl/wl_pkg.sv
// Shared types for the weight loader: FSM state encoding and run-length clamp.
// Pure declarations; no latency or backpressure of its own.
package wl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wl_state_e;

    function automatic logic [31:0] clamp_words(input logic [31:0] n, input logic [31:0] max_n);
        return (n > max_n) ? max_n : n;
    endfunction

endpackage

// File: rtl/wl_bram.sv
// Single-port block RAM, registered read followed by RD_LAT-1 output stages.
// Latency RD_LAT cycles addr->dout; no backpressure.
module wl_bram #(
    parameter int W          = 8,
    parameter int ADDR_WIDTH = 18,
    parameter int RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [W-1:0]          din,
    output logic [W-1:0]          dout
);

    logic [W-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [W-1:0] rd_pipe [RD_LAT];

    always_ff @(posedge clk) begin
        if (en) begin
            if (wen) mem[addr] <= din;
            rd_pipe[0] <= mem[addr];
        end
        for (int s = 1; s < RD_LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
    end

    assign dout = rd_pipe[RD_LAT-1];

endmodule

// File: rtl/wl_valid_pipe.sv
// Tracks issued BRAM reads: DEPTH-deep valid shift register, flushed by reset.
// Latency DEPTH cycles; no backpressure (advances every cycle).
module wl_valid_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_vld,
    output logic out_vld
);

    logic [DEPTH-1:0] sr;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (!rst_n) sr <= '0;
                else        sr <= in_vld;
            end
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (!rst_n) sr <= '0;
                else        sr <= {sr[DEPTH-2:0], in_vld};
            end
        end
    endgenerate

    assign out_vld = sr[DEPTH-1];

endmodule

// File: rtl/weight_loader_param.sv
// Reads a run of weights from BRAM, streams each word and packs it into data_out.
// First word RD_LAT+1 cycles after start, one word/cycle; no backpressure. Optional WL_CHECKSUM_EN.
module weight_loader_param
    import wl_pkg::*;
#(
    parameter int W           = 8,
    parameter int MAX_WEIGHTS = 9216,
    parameter int ADDR_WIDTH  = 18,
    parameter int RD_LAT      = 2,
    parameter int CNT_W       = $clog2(MAX_WEIGHTS + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic [CNT_W-1:0]         num_words,
    output logic                     busy,
    output logic                     done,
    output logic                     w_valid,
    output logic [W-1:0]             w_data,
    output logic [CNT_W-1:0]         w_index,
    output logic [MAX_WEIGHTS*W-1:0] data_out
`ifdef WL_CHECKSUM_EN
    ,
    output logic [W+CNT_W-1:0]       checksum
`endif
);

    wl_state_e             state, state_nxt;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CNT_W-1:0]      n_q, iss_cnt, wr_cnt, last_idx, n_clamped;
    logic [W-1:0]          bram_dout, last_data;
    logic                  accept, issue, bram_en, land;

    assign n_clamped = CNT_W'(clamp_words(32'(num_words), 32'(MAX_WEIGHTS)));
    assign accept    = start && (state == ST_IDLE || state == ST_DONE);
    // Reads issued in the reset cycle are suppressed so nothing lands afterwards.
    assign bram_en   = issue && rst_n;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) state_nxt = (n_clamped == '0) ? ST_DONE : ST_READ;
            end
            ST_READ: begin
                issue = 1'b1;
                if (iss_cnt == n_q - CNT_W'(1)) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (land && wr_cnt == n_q - CNT_W'(1)) state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    wl_bram #(
        .W          (W),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RD_LAT     (RD_LAT)
    ) u_bram (
        .clk  (clk),
        .en   (bram_en),
        .wen  (1'b0),
        .addr (base_q + ADDR_WIDTH'(iss_cnt)),
        .din  ({W{1'b0}}),
        .dout (bram_dout)
    );

    wl_valid_pipe #(
        .DEPTH (RD_LAT)
    ) u_vpipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (bram_en),
        .out_vld (land)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q    <= '0;
            n_q       <= '0;
            iss_cnt   <= '0;
            wr_cnt    <= '0;
            last_data <= '0;
            last_idx  <= '0;
            data_out  <= '0;
        end else begin
            if (accept) begin
                base_q   <= base_addr;
                n_q      <= n_clamped;
                iss_cnt  <= '0;
                wr_cnt   <= '0;
                last_idx <= '0;
                data_out <= '0;
            end
            if (issue) iss_cnt <= iss_cnt + CNT_W'(1);
            if (land) begin
                data_out[wr_cnt*W +: W] <= bram_dout;
                wr_cnt    <= wr_cnt + CNT_W'(1);
                last_data <= bram_dout;
                last_idx  <= wr_cnt;
            end
        end
    end

`ifdef WL_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n || accept) checksum <= '0;
        else if (land)        checksum <= checksum + (W+CNT_W)'(bram_dout);
    end
`endif

    assign busy    = (state == ST_READ) || (state == ST_DRAIN);
    assign done    = (state == ST_DONE);
    assign w_valid = land;
    assign w_data  = land ? bram_dout : last_data;
    assign w_index = land ? wr_cnt : last_idx;

endmodule

// File: tb/tb_weight_loader_param.sv
// Directed bench for weight_loader_param: table of runs plus reset-mid-run sequence.
module tb_weight_loader_param;

    localparam int W      = 8;
    localparam int MAXW   = 9216;
    localparam int AW     = 18;
    localparam int RD_LAT = 2;
    localparam int CNT_W  = 14;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [AW-1:0]     base_addr;
    logic [CNT_W-1:0]  num_words;
    logic              busy, done, w_valid;
    logic [W-1:0]      w_data;
    logic [CNT_W-1:0]  w_index;
    logic [MAXW*W-1:0] data_out;
`ifdef WL_CHECKSUM_EN
    logic [W+CNT_W-1:0] checksum;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    weight_loader_param #(
        .W(W), .MAX_WEIGHTS(MAXW), .ADDR_WIDTH(AW), .RD_LAT(RD_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .busy      (busy),
        .done      (done),
        .w_valid   (w_valid),
        .w_data    (w_data),
        .w_index   (w_index),
        .data_out  (data_out)
`ifdef WL_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    typedef struct {
        logic [AW-1:0] base;
        int            num;
        int            exp_n;
        int            exp_done;
        bit            inject;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input string what, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s/%s: got %0d want %0d", nm, what, act, exp);
        end
    endtask

    function automatic logic [W-1:0] img(input logic [AW-1:0] b, input int i);
        logic [AW-1:0] a;
        a = b + AW'(i);
        return a[W-1:0];
    endfunction

    function automatic int dout_mism(input logic [AW-1:0] b, input int n);
        int m = 0;
        for (int i = 0; i < MAXW; i++) begin
            logic [W-1:0] want;
            want = (i < n) ? img(b, i) : '0;
            if (data_out[i*W +: W] != want) m++;
        end
        return m;
    endfunction

    task automatic run_vec(input vec_t v, input string nm);
        int first_v = -1, done_at = -1, cnt = 0, bad_d = 0, bad_i = 0, busy_bad = 0;
        longint sum = 0;
        bit exp_busy;
        @(negedge clk);
        base_addr = v.base;
        num_words = CNT_W'(v.num);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 1; j <= 20000; j++) begin
            if (v.inject && j == 2) begin
                start = 1'b1; base_addr = 18'd5000; num_words = 14'd3;
            end else begin
                start = 1'b0;
            end
            if (w_valid) begin
                if (first_v < 0) first_v = j;
                if (w_data != img(v.base, cnt)) bad_d++;
                if (w_index != CNT_W'(cnt)) bad_i++;
                sum += longint'(img(v.base, cnt));
                cnt++;
            end
            exp_busy = (v.exp_n > 0) && (j < v.exp_done);
            if (busy != exp_busy) busy_bad++;
            if (done) begin
                done_at = j;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk(nm, "first_valid", first_v, (v.exp_n == 0) ? -1 : RD_LAT + 1);
        chk(nm, "word_count", cnt, v.exp_n);
        chk(nm, "data_errs", bad_d, 0);
        chk(nm, "index_errs", bad_i, 0);
        chk(nm, "done_cycle", done_at, v.exp_done);
        chk(nm, "busy_errs", busy_bad, 0);
        chk(nm, "data_out_errs", dout_mism(v.base, v.exp_n), 0);
`ifdef WL_CHECKSUM_EN
        chk(nm, "checksum", checksum, sum);
`endif
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
        for (int a = 0; a < (1 << AW); a++) begin
            logic [AW-1:0] av;
            av = AW'(a);
            dut.u_bram.mem[a] = av[W-1:0];
        end

        vecs[0] = '{18'd55296,  8,     8,    11,   1'b0};
        vecs[1] = '{18'd0,      0,     0,    1,    1'b0};
        vecs[2] = '{18'd262142, 4,     4,    7,    1'b0};
        vecs[3] = '{18'd777,    1,     1,    4,    1'b0};
        vecs[4] = '{18'd0,      16,    16,   19,   1'b1};
        vecs[5] = '{18'd0,      2,     2,    5,    1'b0};
        vecs[6] = '{18'd100,    16383, 9216, 9219, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset", "busy", busy, 0);
        chk("reset", "done", done, 0);
        chk("reset", "w_valid", w_valid, 0);
        chk("reset", "w_data", w_data, 0);
        chk("reset", "w_index", w_index, 0);
        chk("reset", "data_out_errs", dout_mism('0, 0), 0);
        rst_n = 1'b1;

        for (int t = 0; t < 7; t++) run_vec(vecs[t], $sformatf("vec%0d", t));

        // Reset asserted while word 4 of a 16-word run is on the bus.
        begin
            int found = 0, stray = 0;
            @(negedge clk);
            base_addr = 18'd0; num_words = 14'd16; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int j = 0; j < 100; j++) begin
                if (w_valid && w_index == 14'd3) begin
                    found = 1;
                    break;
                end
                @(negedge clk);
            end
            chk("midrst", "word3_seen", found, 1);
            @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            chk("midrst", "busy", busy, 0);
            chk("midrst", "done", done, 0);
            chk("midrst", "w_valid", w_valid, 0);
            chk("midrst", "w_data", w_data, 0);
            chk("midrst", "w_index", w_index, 0);
            chk("midrst", "data_out_errs", dout_mism('0, 0), 0);
            rst_n = 1'b1;
            for (int j = 0; j < 20; j++) begin
                @(negedge clk);
                if (w_valid || busy) stray++;
            end
            chk("midrst", "stray_activity", stray, 0);
            chk("midrst", "data_out_after", dout_mism('0, 0), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
